// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier: default width, FSM encoding
// and the iteration-counter width.
package mul_pkg;

  localparam int unsigned MUL_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(MUL_WIDTH);

endpackage

// File: rtl/shift_add_mul_adder.sv
// Combinational WIDTH-bit adder with carry out, shared by the multiplier datapath.
module shift_add_mul_adder #(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: one partial-product iteration
// per clock, WIDTH iterations per operation, single-cycle done pulse.
module shift_add_mul
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-2:0]   a_lo;
  logic               c;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   s;
  logic               cout;
  logic [WIDTH-1:0]   acc_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               last;

  // C is stored as the msb of A: the carry shifted right lands exactly there,
  // so A = {C, a_lo} holds after every iteration and C needs no separate copy.
  assign acc    = {c, a_lo};
  assign addend = q[0] ? m : '0;

  shift_add_mul_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x    (acc),
    .y    (addend),
    .s    (s),
    .cout (cout)
  );

  assign acc_nxt = {cout, s[WIDTH-1:1]};
  assign q_nxt   = {s[0], q[WIDTH-1:1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      a_lo  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            a_lo  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          c    <= acc_nxt[WIDTH-1];
          a_lo <= acc_nxt[WIDTH-2:0];
          q    <= q_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            p     <= {acc_nxt, q_nxt};
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter: WIDTH, 6, operand width; SHALL equal the width of the shared adder sub-module.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplicand, unsigned; captured on accepted start.
REQ-006 b  input  WIDTH  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 p  output  2*WIDTH  unsigned product, registered.

Function
REQ-010 FSM states SHALL be IDLE, RUN, DONE; encoding from shared package.
REQ-011 IDLE: on edge with start=1, latch M=a, Q=b, A=0, C=0, cnt=0, go to RUN; start=0 stays IDLE.
REQ-012 RUN: each edge performs one iteration: {C,A} = A + (Q[0] ? M : 0) via the shared adder; then {A,Q} = {C,A,Q} >> 1 (C shifted into A msb); cnt increments.
REQ-013 RUN SHALL last exactly WIDTH edges; on the edge where cnt = WIDTH-1, go to DONE.
REQ-014 Adder inputs SHALL be x=A, y=(Q[0] ? M : 0) every cycle; sum s and carry cout used only in RUN.
REQ-015 DONE: done=1 for exactly one cycle (Moore output), p={A,Q} loaded on entry to DONE, next edge returns to IDLE.
REQ-016 Latency: start sampled at edge E; done high between edges E+WIDTH and E+WIDTH+1 (E+6..E+7 at WIDTH=6).
REQ-017 p SHALL hold its value from DONE until the next DONE; it SHALL not change during RUN.
REQ-018 start while busy=1 (RUN or DONE) SHALL be ignored; a and b changes while busy SHALL not affect the result.
REQ-019 Earliest next accepted start is the edge after DONE returns to IDLE: throughput one multiply per WIDTH+2 cycles.
REQ-020 Result SHALL equal a*b exactly for all 2^(2*WIDTH) operand pairs; no overflow possible in 2*WIDTH bits.
REQ-021 Boundaries: a=0 or b=0 gives p=0; a=b=2^WIDTH-1 gives p=(2^WIDTH-1)^2 with carry propagated via C.

Reset
REQ-022 rst=1 SHALL immediately (no clock) force state IDLE, busy=0, done=0, p=0, A=Q=M=0, C=0, cnt=0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow release.
REQ-024 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-025 Shared package mul_pkg SHALL hold WIDTH default, state encoding localparams, and counter width ($clog2(WIDTH)).
REQ-026 Exactly one sub-module: the existing combinational adder (ports x, y, s, cout) instantiated once; no other adder logic in the block.
REQ-027 Datapath registers A, Q, M, C, cnt and p SHALL reside in shift_add_mul; FSM in the same file.

Verification
REQ-028 a=0, b=0, start pulse -> done at E+6, p=0, busy high E+1..E+7 edges.
REQ-029 a=63, b=63 -> p=3969 (0xF81); a=45, b=27 -> p=1215 (0x4BF).
REQ-030 start=1 held continuously with a=5, b=7, operands changed to 9/9 during RUN -> p=35 once per 8 cycles, second op captures values at its accept edge.
REQ-031 a=63, b=63, rst pulsed at E+3 asynchronously (mid-cycle) -> busy=0, p=0 immediately, no done pulse.
REQ-032 Exhaustive sweep of all 64*64 pairs, back-to-back -> every done pulse matches a*b; 4096 done pulses total.
